// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo frame scheduler.
// Holds the sequencer states, position type and pulse-width math.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SLOT,
        TAIL
    } state_t;

    typedef logic [7:0] pos_t;

    localparam int RESET_POS_DEF = 128;

    function automatic int unsigned calc_width(
        input pos_t        pos,
        input int unsigned min_t,
        input int unsigned step_t
    );
        return min_t + 32'(pos) * step_t;
    endfunction

endpackage

// File: rtl/servo_slew_unit.sv
// Per-channel target/current position pair.
// Current position walks toward the target once per frame.
module servo_slew_unit
    import servo_pkg::*;
#(
    parameter int RESET_POS = RESET_POS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wr,
    input  pos_t i_pos,
    input  logic i_upd,
    input  pos_t i_slew,
    output pos_t o_cur,
    output logic o_at_target
);

    pos_t r_cur;
    pos_t r_tgt;
    pos_t w_up;
    pos_t w_dn;

    assign w_up = r_tgt - r_cur;
    assign w_dn = r_cur - r_tgt;

    // Step is clamped to the remaining distance, so no overshoot or wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur <= 8'(RESET_POS);
            r_tgt <= 8'(RESET_POS);
        end else begin
            if (i_upd) begin
                if (r_tgt > r_cur) begin
                    r_cur <= (w_up > i_slew) ? r_cur + i_slew : r_tgt;
                end else if (r_tgt < r_cur) begin
                    r_cur <= (w_dn > i_slew) ? r_cur - i_slew : r_tgt;
                end
            end
            if (i_wr) begin
                r_tgt <= i_pos;
            end
        end
    end

    assign o_cur       = r_cur;
    assign o_at_target = (r_cur == r_tgt);

endmodule

// File: rtl/servo_frame_scheduler.sv
// Time-shared multi-channel servo PWM sequencer.
// One frame counter serves all channels; each gets a fixed slot.
module servo_frame_scheduler
    import servo_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int FRAME_TICKS = 200000,
    parameter int SLOT_TICKS  = 25000,
    parameter int MIN_TICKS   = 10000,
    parameter int STEP_TICKS  = 40,
    parameter int SLEW_STEP   = 1,
    parameter int RESET_POS   = RESET_POS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CH_W-1:0]   wr_chan,
    input  pos_t              wr_pos,
    output logic              wr_err,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_start,
    output logic [NUM_CH-1:0] at_target
);

    localparam int SW = $clog2(SLOT_TICKS);
    localparam int WW = SW + 1;
    localparam int FW = $clog2(FRAME_TICKS);
    localparam bit NO_TAIL = (NUM_CH * SLOT_TICKS == FRAME_TICKS);
    localparam logic [SW-1:0]   SLOT_LAST  = SW'(SLOT_TICKS - 1);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);
    localparam int unsigned     NCH_U      = NUM_CH;

    state_t            r_state;
    logic [FW-1:0]     r_frame_cnt;
    logic [SW-1:0]     r_slot_cnt;
    logic [CH_W-1:0]   r_ch_cnt;
    logic [NUM_CH-1:0] r_pwm;
    logic              r_fs;
    logic              r_err;

    logic              w_slot_end;
    logic              w_last_ch;
    logic              w_frame_end;
    logic              w_upd;
    logic              w_acc;
    logic              w_bad;
    logic [NUM_CH-1:0] w_pwm_nxt;
    pos_t              w_cur   [NUM_CH];
    logic [WW-1:0]     w_width [NUM_CH];

    assign w_slot_end = (r_slot_cnt == SLOT_LAST);
    assign w_last_ch  = (r_ch_cnt == CH_LAST);

    always_comb begin
        w_frame_end = 1'b0;
        unique case (1'b1)
            (r_state == SLOT): w_frame_end = w_slot_end && w_last_ch && NO_TAIL;
            (r_state == TAIL): w_frame_end = (r_frame_cnt == FRAME_LAST);
            default:           w_frame_end = 1'b0;
        endcase
    end

    // The edge that restarts a frame also slews; writes wait one cycle.
    assign w_upd    = ena && ((r_state == IDLE) || w_frame_end);
    assign wr_ready = !w_upd;
    assign w_acc    = wr_valid && wr_ready;
    assign w_bad    = (32'(wr_chan) >= NCH_U);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [CH_W-1:0] KC = CH_W'(k);

        servo_slew_unit #(
            .RESET_POS (RESET_POS)
        ) u_slew (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_wr        (w_acc && (wr_chan == KC)),
            .i_pos       (wr_pos),
            .i_upd       (w_upd),
            .i_slew      (8'(SLEW_STEP)),
            .o_cur       (w_cur[k]),
            .o_at_target (at_target[k])
        );

        assign w_width[k]   = WW'(calc_width(w_cur[k], MIN_TICKS, STEP_TICKS));
        assign w_pwm_nxt[k] = (r_ch_cnt == KC) && (WW'(r_slot_cnt) < w_width[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
            r_slot_cnt  <= '0;
            r_ch_cnt    <= '0;
            r_pwm       <= '0;
            r_fs        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_fs  <= w_upd;
            r_err <= w_acc && w_bad;
            r_pwm <= '0;
            if (!ena) begin
                r_state     <= IDLE;
                r_frame_cnt <= '0;
                r_slot_cnt  <= '0;
                r_ch_cnt    <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state     <= SLOT;
                        r_frame_cnt <= '0;
                        r_slot_cnt  <= '0;
                        r_ch_cnt    <= '0;
                    end
                    SLOT: begin
                        r_pwm       <= w_pwm_nxt;
                        r_frame_cnt <= w_frame_end ? '0 : r_frame_cnt + 1'b1;
                        if (w_slot_end) begin
                            r_slot_cnt <= '0;
                            if (w_last_ch) begin
                                r_ch_cnt <= '0;
                                if (!NO_TAIL) begin
                                    r_state <= TAIL;
                                end
                            end else begin
                                r_ch_cnt <= r_ch_cnt + 1'b1;
                            end
                        end else begin
                            r_slot_cnt <= r_slot_cnt + 1'b1;
                        end
                    end
                    TAIL: begin
                        if (w_frame_end) begin
                            r_frame_cnt <= '0;
                            r_state     <= SLOT;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign pwm_out     = r_pwm;
    assign frame_start = r_fs;
    assign wr_err      = r_err;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Scoreboard bench: two DUTs (slew 1 and slew 255) share stimulus.
// A frame-level model queues expected pulses; a monitor checks them.
module tb_servo_frame_scheduler;

    localparam int F     = 700;
    localparam int S     = 300;
    localparam int MINT  = 10;
    localparam int STEPT = 1;

    typedef struct {
        int v;
        int k;
        int st;
        int w;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_chan = 2'd0;
    logic [7:0] wr_pos = 8'd0;

    logic       rdy [2];
    logic       err [2];
    logic       fs  [2];
    logic [1:0] pwm [2];
    logic [1:0] at  [2];

    int     cyc = 0;
    bit     m_run = 1'b0;
    int     m_pos = 0;
    int     m_cur [2][2];
    int     m_tgt [2][2];
    bit     exp_err = 1'b0;
    bit     m_upd;
    bit     m_acc;
    pulse_t eq [$];

    int rd [2] = '{0, 0};
    bit prv [2][2];
    int pst [2][2];
    int pcn [2][2];
    int n_chk = 0;
    int n_err = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    servo_frame_scheduler #(
        .NUM_CH(2), .CH_W(2), .FRAME_TICKS(F), .SLOT_TICKS(S),
        .MIN_TICKS(MINT), .STEP_TICKS(STEPT), .SLEW_STEP(1), .RESET_POS(128)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .wr_valid(wr_valid), .wr_ready(rdy[0]),
        .wr_chan(wr_chan), .wr_pos(wr_pos), .wr_err(err[0]),
        .pwm_out(pwm[0]), .frame_start(fs[0]), .at_target(at[0])
    );

    servo_frame_scheduler #(
        .NUM_CH(2), .CH_W(2), .FRAME_TICKS(F), .SLOT_TICKS(S),
        .MIN_TICKS(MINT), .STEP_TICKS(STEPT), .SLEW_STEP(255), .RESET_POS(128)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .wr_valid(wr_valid), .wr_ready(rdy[1]),
        .wr_chan(wr_chan), .wr_pos(wr_pos), .wr_err(err[1]),
        .pwm_out(pwm[1]), .frame_start(fs[1]), .at_target(at[1])
    );

    function automatic int slew_of(input int v);
        return (v == 0) ? 1 : 255;
    endfunction

    // ---------------- reference model ----------------
    task automatic truncate(input int d);
        pulse_t p;
        for (int i = 0; i < eq.size(); i++) begin
            p = eq[i];
            if (p.w > 0 && p.st + p.w > d) begin
                p.w = (p.st >= d) ? 0 : d - p.st;
                eq[i] = p;
            end
        end
    endtask

    task automatic model_reset();
        truncate(cyc);
        m_run   = 1'b0;
        m_pos   = 0;
        exp_err = 1'b0;
        for (int v = 0; v < 2; v++)
            for (int k = 0; k < 2; k++) begin
                m_cur[v][k] = 128;
                m_tgt[v][k] = 128;
            end
    endtask

    task automatic frame_begin();
        int d;
        int st;
        pulse_t p;
        for (int v = 0; v < 2; v++)
            for (int k = 0; k < 2; k++) begin
                st = slew_of(v);
                d  = m_tgt[v][k] - m_cur[v][k];
                if (d > st) m_cur[v][k] += st;
                else if (d < -st) m_cur[v][k] -= st;
                else m_cur[v][k] = m_tgt[v][k];
                p.v  = v;
                p.k  = k;
                p.st = cyc + k * S + 1;
                p.w  = MINT + m_cur[v][k] * STEPT;
                eq.push_back(p);
            end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            cyc++;
            m_upd = ena && (!m_run || m_pos == F - 1);
            m_acc = wr_valid && !m_upd;
            if (!ena) begin
                truncate(cyc);
                m_run = 1'b0;
                m_pos = 0;
            end else if (m_upd) begin
                m_run = 1'b1;
                m_pos = 0;
                frame_begin();
            end else begin
                m_pos++;
            end
            exp_err = m_acc && (wr_chan >= 2);
            if (m_acc && wr_chan < 2)
                for (int v = 0; v < 2; v++) m_tgt[v][wr_chan] = int'(wr_pos);
        end
    end

    // ---------------- monitor ----------------
    task automatic check(input string nm, input int got, input int exp_v);
        n_chk++;
        if (got != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp_v, cyc);
        end
    endtask

    function automatic bit exp_rdy();
        return !(ena && (!m_run || m_pos == F - 1));
    endfunction

    function automatic logic [1:0] exp_at(input int v);
        logic [1:0] r;
        for (int k = 0; k < 2; k++) r[k] = (m_cur[v][k] == m_tgt[v][k]);
        return r;
    endfunction

    task automatic chk_pulse(input int v, input int k, input int st, input int w);
        int i;
        pulse_t p;
        i = rd[v];
        while (i < eq.size() && (eq[i].v != v || eq[i].w == 0)) i++;
        if (i >= eq.size()) begin
            n_chk++;
            n_err++;
            $display("FAIL pulse_extra: dut%0d ch%0d start %0d width %0d, no pulse required",
                     v, k, st, w);
        end else begin
            p = eq[i];
            rd[v] = i + 1;
            check($sformatf("pulse_ch dut%0d", v), k, p.k);
            check($sformatf("pulse_start dut%0d ch%0d", v, k), st, p.st);
            check($sformatf("pulse_width dut%0d ch%0d", v, k), w, p.w);
        end
    endtask

    always @(negedge clk) begin
        int pend;
        for (int v = 0; v < 2; v++) begin
            check($sformatf("wr_ready dut%0d", v), int'(rdy[v]), int'(exp_rdy()));
            check($sformatf("wr_err dut%0d", v), int'(err[v]), int'(exp_err));
            check($sformatf("frame_start dut%0d", v), int'(fs[v]),
                  int'(m_run && m_pos == 0));
            check($sformatf("at_target dut%0d", v), int'(at[v]), int'(exp_at(v)));
            check($sformatf("pwm_onehot dut%0d", v), int'($countones(pwm[v]) <= 1), 1);
            if (!m_run) check($sformatf("pwm_idle dut%0d", v), int'(pwm[v]), 0);
            for (int k = 0; k < 2; k++) begin
                if (pwm[v][k]) begin
                    if (!prv[v][k]) begin
                        pst[v][k] = cyc;
                        pcn[v][k] = 0;
                    end
                    pcn[v][k]++;
                end else if (prv[v][k]) begin
                    chk_pulse(v, k, pst[v][k], pcn[v][k]);
                end
                prv[v][k] = pwm[v][k];
            end
        end
        if (done) begin
            for (int v = 0; v < 2; v++) begin
                pend = 0;
                for (int i = rd[v]; i < eq.size(); i++)
                    if (eq[i].v == v && eq[i].w > 0) pend++;
                check($sformatf("pending_pulses dut%0d", v), pend, 0);
            end
            $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int p);
        int g = 0;
        while (!(m_run && m_pos == p) && g < 2 * F) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!(m_run && m_pos == p)) begin
            $display("FAIL wait_pos: frame position %0d not reached", p);
            $fatal(1, "stimulus timeout");
        end
    endtask

    task automatic write_req(input int ch, input int pos);
        bit r = 1'b0;
        int n = 0;
        wr_valid = 1'b1;
        wr_chan  = 2'(ch);
        wr_pos   = 8'(pos);
        while (!r && n < 10) begin
            @(negedge clk);
            r = rdy[0];
            @(posedge clk);
            #1;
            n++;
        end
        wr_valid = 1'b0;
        wr_pos   = 8'($urandom_range(255));
        if (!r) begin
            $display("FAIL write_req: channel %0d never accepted", ch);
            $fatal(1, "handshake timeout");
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(3);
        ena = 1'b1;
        run(2 * F + 10);
        write_req(0, 130);
        run(4 * F);
        write_req(0, 0);
        run(2 * F);
        write_req(0, 255);
        run(2 * F);
        write_req(3, 77);
        run($urandom_range(5, 50));
        write_req(2, 5);
        run(F);
        for (int i = 0; i < 3; i++) begin
            run($urandom_range(1, 200));
            write_req(int'($urandom_range(1)), int'($urandom_range(255)));
        end
        run(2 * F);
        wait_pos(F - 1);
        write_req(1, 200);
        run(2 * F);
        wait_pos(S + 50);
        ena = 1'b0;
        run(20);
        ena = 1'b1;
        run(2 * F);
        wait_pos(60);
        do_reset();
        run(2 * F);
        wait_pos(2 * S + 20);
        ena = 1'b0;
        run(5);
        done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
